// File: rtl/pc_unit_pkg.sv
// Shared CPU definitions: PC-unit state encoding and the default reset/exception vectors.
package cpu_defs;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_EXC_PC   = 32'h0000_4180;
  localparam int          DEFAULT_STEP     = 4;

  function automatic logic misaligned(input logic [1:0] low);
    return low != 2'b00;
  endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Bundle of the PC unit's control inputs and fetch-address outputs, as seen by a fetch stage.
interface pc_unit_if #(
  parameter int WIDTH = 32
) ();

  logic             stall;
  logic             redirect;
  logic [WIDTH-1:0] target;
  logic             exc;
  logic             eret;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_next_seq;
  logic             flush;
  logic             pending;
  logic             misalign;

  modport master (
    output stall, redirect, target, exc, eret, epc,
    input  pc, pc_next_seq, flush, pending, misalign
  );

  modport slave (
    input  stall, redirect, target, exc, eret, epc,
    output pc, pc_next_seq, flush, pending, misalign
  );

endinterface

// File: rtl/pc_unit.sv
// Program counter with prioritised next-PC selection, a one-entry buffer for redirects
// that arrive during a stall, a registered flush pulse and a sticky misalignment flag.
module pc_unit
  import cpu_defs::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(DEFAULT_EXC_PC),
  parameter int               STEP     = DEFAULT_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] target,
  input  logic             exc,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             flush,
  output logic             pending,
  output logic             misalign
);

  pc_state_t        state, state_next;
  logic [WIDTH-1:0] buffer, buffer_next;
  logic [WIDTH-1:0] pc_next;
  logic             nonseq;

  assign pc_next_seq = pc + WIDTH'(STEP);
  assign pending     = (state == HOLD);

  // Next-PC priority: exception, return, redirect (live beats buffered), stall, sequential.
  always_comb begin
    state_next  = state;
    buffer_next = buffer;
    pc_next     = pc_next_seq;
    nonseq      = 1'b0;
    if (exc) begin
      pc_next    = EXC_PC;
      nonseq     = 1'b1;
      state_next = IDLE;
    end else if (eret) begin
      pc_next    = epc;
      nonseq     = 1'b1;
      state_next = IDLE;
    end else if (redirect && !stall) begin
      pc_next    = target;
      nonseq     = 1'b1;
      state_next = IDLE;
    end else if (redirect) begin
      pc_next     = pc;
      buffer_next = target;
      state_next  = HOLD;
    end else if (state == HOLD && !stall) begin
      pc_next    = buffer;
      nonseq     = 1'b1;
      state_next = IDLE;
    end else if (stall) begin
      pc_next = pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      buffer   <= '0;
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      buffer <= buffer_next;
      flush  <= nonseq;
      if (nonseq && misaligned(pc_next[1:0])) begin
        misalign <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a 32-bit default instance and an 8-bit wrap instance share
// one stimulus stream; expected states come from an arithmetic reference model.
module tb_pc_unit;

  typedef struct {
    bit          rst;
    bit          stall;
    bit          redirect;
    logic [31:0] target;
    bit          exc;
    bit          eret;
    logic [31:0] epc;
  } stim_t;

  typedef struct {
    longint pc;
    longint bufv;
    bit     pend;
    bit     mis;
    bit     flush;
  } mstate_t;

  typedef struct {
    mstate_t a;
    mstate_t b;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   check_count = 0;
  int   error_count = 0;
  exp_t exp_q[$];
  mstate_t m32, m8;

  pc_unit_if #(.WIDTH(32)) if32 ();
  pc_unit_if #(.WIDTH(8))  if8 ();

  always #5 clk = ~clk;

  pc_unit dut32 (
    .clk(clk), .reset(reset),
    .stall(if32.stall), .redirect(if32.redirect), .target(if32.target),
    .exc(if32.exc), .eret(if32.eret), .epc(if32.epc),
    .pc(if32.pc), .pc_next_seq(if32.pc_next_seq), .flush(if32.flush),
    .pending(if32.pending), .misalign(if32.misalign)
  );

  pc_unit #(.WIDTH(8), .RESET_PC(8'hF8)) dut8 (
    .clk(clk), .reset(reset),
    .stall(if8.stall), .redirect(if8.redirect), .target(if8.target),
    .exc(if8.exc), .eret(if8.eret), .epc(if8.epc),
    .pc(if8.pc), .pc_next_seq(if8.pc_next_seq), .flush(if8.flush),
    .pending(if8.pending), .misalign(if8.misalign)
  );

  // Reference model: the PC as an integer modulo 2^w, the buffer as a remembered value.
  function automatic mstate_t model_step(mstate_t m, stim_t s, int w, longint rpc, longint xpc);
    longint  mask = (longint'(1) << w) - 1;
    mstate_t n = m;
    longint  ld = 0;
    bit      load = 0;
    n.flush = 0;
    if (s.rst) begin
      n.pc = rpc; n.bufv = 0; n.pend = 0; n.mis = 0;
      return n;
    end
    if (s.exc) begin
      ld = xpc; load = 1; n.pend = 0;
    end else if (s.eret) begin
      ld = longint'(s.epc) & mask; load = 1; n.pend = 0;
    end else if (s.redirect && !s.stall) begin
      ld = longint'(s.target) & mask; load = 1; n.pend = 0;
    end else if (s.redirect) begin
      n.bufv = longint'(s.target) & mask; n.pend = 1;
    end else if (m.pend && !s.stall) begin
      ld = m.bufv; load = 1; n.pend = 0;
    end else if (!s.stall) begin
      n.pc = (m.pc + 4) % (mask + 1);
    end
    if (load) begin
      n.pc = ld;
      n.flush = 1;
      if (ld % 4 != 0) n.mis = 1;
    end
    return n;
  endfunction

  function automatic stim_t mk(bit rst, bit stall, bit redirect, logic [31:0] target,
                               bit exc, bit eret, logic [31:0] epc);
    stim_t s;
    s.rst = rst; s.stall = stall; s.redirect = redirect; s.target = target;
    s.exc = exc; s.eret = eret; s.epc = epc;
    return s;
  endfunction

  task automatic checkOutput(input string name, input longint act, input longint exp);
    check_count++;
    if (act !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    reset = s.rst;
    if32.stall = s.stall; if32.redirect = s.redirect; if32.target = s.target;
    if32.exc = s.exc; if32.eret = s.eret; if32.epc = s.epc;
    if8.stall = s.stall; if8.redirect = s.redirect; if8.target = s.target[7:0];
    if8.exc = s.exc; if8.eret = s.eret; if8.epc = s.epc[7:0];
    m32 = model_step(m32, s, 32, 64'h3000, 64'h4180);
    m8  = model_step(m8, s, 8, 64'hF8, 64'h80);
    exp_q.push_back('{m32, m8});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(mk(0, 0, 0, 0, 0, 0, 0));
  endtask

  // Monitor: every edge the DUTs present a new state; compare it to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("pc32", longint'(if32.pc), e.a.pc);
        checkOutput("seq32", longint'(if32.pc_next_seq), (e.a.pc + 4) & 64'hFFFF_FFFF);
        checkOutput("flush32", longint'(if32.flush), longint'(e.a.flush));
        checkOutput("pending32", longint'(if32.pending), longint'(e.a.pend));
        checkOutput("misalign32", longint'(if32.misalign), longint'(e.a.mis));
        checkOutput("pc8", longint'(if8.pc), e.b.pc);
        checkOutput("seq8", longint'(if8.pc_next_seq), (e.b.pc + 4) & 64'hFF);
        checkOutput("flush8", longint'(if8.flush), longint'(e.b.flush));
        checkOutput("pending8", longint'(if8.pending), longint'(e.b.pend));
        checkOutput("misalign8", longint'(if8.misalign), longint'(e.b.mis));
      end
    end
  end

  initial begin
    stim_t s;
    int    budget;
    m32 = '{0, 0, 0, 0, 0};
    m8  = '{0, 0, 0, 0, 0};
    if32.stall = 0; if32.redirect = 0; if32.target = 0; if32.exc = 0; if32.eret = 0; if32.epc = 0;
    if8.stall = 0; if8.redirect = 0; if8.target = 0; if8.exc = 0; if8.eret = 0; if8.epc = 0;
    @(negedge clk);

    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0));
    checkOutput("reset_pc32", longint'(if32.pc), 64'h3000);
    checkOutput("reset_flags32", longint'({if32.flush, if32.pending, if32.misalign}), 0);
    checkOutput("reset_pc8", longint'(if8.pc), 64'hF8);
    idle(2);
    checkOutput("wrap_pc8", longint'(if8.pc), 64'h00);
    idle(1);
    checkOutput("seq_pc32", longint'(if32.pc), 64'h300C);

    applyStimulus(mk(1, 0, 0, 0, 0, 0, 0));
    idle(1);
    applyStimulus(mk(0, 0, 1, 32'h3040, 0, 0, 0));
    checkOutput("redirect_pc", longint'(if32.pc), 64'h3040);
    checkOutput("redirect_flush", longint'(if32.flush), 1);
    idle(1);
    checkOutput("flush_drop", longint'(if32.flush), 0);

    applyStimulus(mk(0, 1, 1, 32'h3100, 0, 0, 0));
    checkOutput("held_pc", longint'(if32.pc), 64'h3044);
    checkOutput("held_pending", longint'(if32.pending), 1);
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, 1, 0, 0, 0, 0, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0));
    checkOutput("release_pc", longint'(if32.pc), 64'h3100);
    checkOutput("release_flags", longint'({if32.pending, if32.flush}), 64'h1);

    applyStimulus(mk(0, 1, 1, 32'h3200, 0, 0, 0));
    applyStimulus(mk(0, 1, 1, 32'h3300, 1, 0, 0));
    checkOutput("exc_pc", longint'(if32.pc), 64'h4180);
    checkOutput("exc_pending", longint'(if32.pending), 0);
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 32'h3008));
    checkOutput("eret_pc", longint'(if32.pc), 64'h3008);

    applyStimulus(mk(0, 0, 1, 32'h3042, 0, 0, 0));
    checkOutput("misalign_pc", longint'(if32.pc), 64'h3042);
    idle(5);
    checkOutput("misalign_sticky", longint'(if32.misalign), 1);

    applyStimulus(mk(0, 1, 1, 32'h30A0, 0, 0, 0));
    applyStimulus(mk(1, 1, 0, 0, 0, 0, 0));
    checkOutput("midreset_pc8", longint'(if8.pc), 64'hF8);
    checkOutput("midreset_pending8", longint'(if8.pending), 0);
    checkOutput("midreset_misalign32", longint'(if32.misalign), 0);

    // Random phase: biased toward stalls and redirects so the buffer path is busy.
    for (int i = 0; i < 400; i++) begin
      s.rst      = ($urandom_range(99) < 2);
      s.exc      = ($urandom_range(99) < 4);
      s.eret     = ($urandom_range(99) < 5);
      s.redirect = ($urandom_range(99) < 30);
      s.stall    = ($urandom_range(99) < 45);
      s.target   = $urandom();
      s.epc      = $urandom();
      if ($urandom_range(9) != 0) begin
        s.target[1:0] = 2'b00;
        s.epc[1:0]    = 2'b00;
      end
      applyStimulus(s);
    end

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() > 0) begin
      check_count++;
      error_count++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
